// File: rtl/window_line_buffer_ctrl.sv
// 3x3 sliding-window generator over a four-line circular buffer.
// Pixels arrive in raster order; once three complete lines are buffered the
// read FSM sweeps across them and emits one 3x3 window per cycle, then pulses
// o_intr on the last window of each line. Writes continue during reads: the
// fourth buffer absorbs the incoming line while the other three are read.
module window_line_buffer_ctrl #(
    parameter int LINE_WIDTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);

    localparam int PW = $clog2(LINE_WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Four line buffers: synchronous write, asynchronous read.
    logic [7:0]    line_mem [0:3][0:LINE_WIDTH-1];

    logic [PW-1:0] wr_ptr;
    logic [1:0]    wr_sel;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    rd_sel;
    logic [2:0]    filled_lines;
    state_t        state;
    state_t        state_next;

    logic          write_done;
    logic          issue;
    logic          read_done;
    logic [71:0]   window;

    // The last pixel of a line completes that line.
    assign write_done = i_pixel_data_valid && (wr_ptr == PW'(LINE_WIDTH - 1));

    // Store each valid pixel into the line currently being filled.
    always_ff @(posedge clk) begin
        if (!reset && i_pixel_data_valid) begin
            line_mem[wr_sel][wr_ptr] <= i_pixel_data;
        end
    end

    // Write column pointer and write-line selector.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            wr_sel <= 2'd0;
        end else if (i_pixel_data_valid) begin
            if (write_done) begin
                wr_ptr <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Count of complete, not yet consumed lines; simultaneous events cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            filled_lines <= 3'd0;
        end else begin
            case ({write_done, read_done})
                2'b10:   filled_lines <= filled_lines + 3'd1;
                2'b01:   filled_lines <= filled_lines - 3'd1;
                default: filled_lines <= filled_lines;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: READ needs three complete lines and is entered only from IDLE.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        read_done  = 1'b0;
        case (state)
            IDLE: begin
                if (filled_lines >= 3'd3) begin
                    state_next = READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                issue = 1'b1;
                if (rd_ptr == PW'(LINE_WIDTH - 3)) begin
                    read_done  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = READ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read column pointer and oldest-line selector.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            rd_sel <= 2'd0;
        end else if (read_done) begin
            rd_ptr <= '0;
            rd_sel <= rd_sel + 2'd1;
        end else if (issue) begin
            rd_ptr <= rd_ptr + PW'(1);
        end else begin
            rd_ptr <= rd_ptr;
        end
    end

    // Assemble the 3x3 window: row 0 is the oldest line, column 0 leftmost.
    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window[(r*3+c)*8 +: 8] = line_mem[rd_sel + 2'(r)][rd_ptr + PW'(c)];
            end
        end
    end

    // Registered outputs; the window is held while no new one is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_pixel_data       <= 72'd0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= issue;
            o_intr             <= read_done;
            if (issue) begin
                o_pixel_data <= window;
            end else begin
                o_pixel_data <= o_pixel_data;
            end
        end
    end

endmodule

// File: tb/tb_window_line_buffer_ctrl.sv
// Bench for window_line_buffer_ctrl. The reference model keeps every written
// line as an array of pixels and predicts window timing from line completion
// edges: output line k starts reading one edge after both line k+2 is complete
// and line k-1 has finished, and each window appears one edge after it is read.
module tb_window_line_buffer_ctrl;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix;
    logic        pv;
    logic [71:0] opd;
    logic        opv;
    logic        ointr;

    always #5 clk = ~clk;

    window_line_buffer_ctrl #(.LINE_WIDTH(LW)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pv),
        .o_pixel_data       (opd),
        .o_pixel_data_valid (opv),
        .o_intr             (ointr)
    );

    // model state
    int          n = 0;
    int          lines_done = 0;
    int          col_m = 0;
    int          line_edge [32];
    logic [7:0]  mline [32][LW];
    bit          last_rst = 1'b0;
    int          k = 0;
    int          e_prev = -100;
    logic [71:0] exp_last = 72'd0;

    // observation record per reset epoch
    int          win_cnt = 0;
    int          intr_cnt = 0;
    int          first_edge = -1;
    int          rst_edge = 0;
    logic [71:0] hist [64];

    int          checks = 0;
    int          fails = 0;

    task automatic check72(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic compare();
        logic [71:0] exp_d;
        bit          exp_v;
        bit          exp_i;
        int          a;
        int          rr;
        int          j;
        exp_v = 1'b0;
        exp_i = 1'b0;
        exp_d = exp_last;
        if (last_rst) begin
            k          = 0;
            e_prev     = -100;
            exp_last   = 72'd0;
            exp_d      = 72'd0;
            win_cnt    = 0;
            intr_cnt   = 0;
            first_edge = -1;
        end else if (lines_done >= k + 3) begin
            a  = line_edge[k+2];
            rr = ((a > e_prev) ? a : e_prev) + 1;
            if (n >= rr + 1 && n <= rr + LW - 2) begin
                j     = n - rr - 1;
                exp_v = 1'b1;
                exp_i = (j == LW - 3);
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        exp_d[(r*3+c)*8 +: 8] = mline[k+r][j+c];
                    end
                end
                exp_last = exp_d;
                if (j == LW - 3) begin
                    e_prev = n;
                    k++;
                end
            end
        end
        checki("valid", int'(opv), int'(exp_v));
        checki("intr", int'(ointr), int'(exp_i));
        check72("window", opd, exp_d);
        checki("filled_le_4", (dut.filled_lines <= 3'd4) ? 1 : 0, 1);
        if (opv === 1'b1) begin
            if (win_cnt < 64) hist[win_cnt] = opd;
            if (win_cnt == 0) first_edge = n;
            win_cnt++;
        end
        if (ointr === 1'b1) intr_cnt++;
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] p);
        reset = r;
        pv    = v;
        pix   = p;
        @(posedge clk);
        n++;
        last_rst = r;
        if (r) begin
            lines_done = 0;
            col_m      = 0;
            rst_edge   = n;
        end else if (v && lines_done < 32) begin
            mline[lines_done][col_m] = p;
            col_m++;
            if (col_m == LW) begin
                line_edge[lines_done] = n;
                lines_done++;
                col_m = 0;
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        step(1'b1, 1'($urandom), 8'($urandom));
    endtask

    task automatic idle(input int cycles);
        for (int t = 0; t < cycles; t++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic stream(input int nlines, input logic [7:0] base, input int gap_pct);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < LW; c++) begin
                while ($urandom_range(99, 0) < gap_pct) step(1'b0, 1'b0, 8'($urandom));
                step(1'b0, 1'b1, base + 8'(l * 16 + c));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        pv    = 1'b0;
        pix   = 8'd0;

        // reset with random inputs for two cycles
        do_reset();
        do_reset();
        check72("reset_data", opd, 72'd0);
        idle(3);

        // six continuous lines: first window, line drain, selector wrap
        do_reset();
        stream(6, 8'h00, 0);
        idle(30);
        checki("first_latency", first_edge - rst_edge, 26);
        check72("first_window", hist[0], 72'h22_21_20_12_11_10_02_01_00);
        check72("line0_last", hist[5], 72'h27_26_25_17_16_15_07_06_05);
        check72("line3_first", hist[18], 72'h52_51_50_42_41_40_32_31_30);
        check72("line3_last", hist[23], 72'h57_56_55_47_46_45_37_36_35);
        checki("wrap_windows", win_cnt, 24);
        checki("wrap_intr", intr_cnt, 4);

        // gappy input on four lines
        do_reset();
        stream(4, 8'h00, 50);
        idle(30);
        check72("gappy_first", hist[0], 72'h22_21_20_12_11_10_02_01_00);
        check72("gappy_l1_last", hist[11], 72'h37_36_35_27_26_25_17_16_15);
        checki("gappy_windows", win_cnt, 12);
        checki("gappy_intr", intr_cnt, 2);

        // reset at the third window of line 0, then fresh lines
        do_reset();
        stream(3, 8'h00, 0);
        for (int t = 0; t < 50 && win_cnt < 3; t++) step(1'b0, 1'b0, 8'd0);
        checki("midread_reach", win_cnt, 3);
        step(1'b1, 1'b1, 8'hEE);
        stream(3, 8'h80, 0);
        idle(20);
        check72("fresh_first", hist[0], 72'hA2_A1_A0_92_91_90_82_81_80);
        checki("fresh_windows", win_cnt, 6);

        // random pixel values with random gaps
        do_reset();
        for (int l = 0; l < 5; l++) begin
            for (int c = 0; c < LW; c++) begin
                while ($urandom_range(99, 0) < 30) step(1'b0, 1'b0, 8'($urandom));
                step(1'b0, 1'b1, 8'($urandom));
            end
        end
        idle(30);
        checki("rand_windows", win_cnt, 18);
        checki("rand_intr", intr_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
